// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle instruction phase sequencer for the MIPS datapath: walks FETCH/DECODE/EXEC/MEM/WB
// with memory handshakes, run/step/halt control, an ack watchdog and activity counters.
module cpu_phase_sequencer #(
    parameter int ACK_TIMEOUT = 15,
    parameter int TO_WIDTH    = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step,
    input  logic                 halt_req,
    input  logic                 is_mem_op,
    input  logic                 mem_is_write,
    input  logic                 reg_write_req,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic                 reg_we,
    output logic [2:0]           phase,
    output logic                 busy,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(ACK_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic                  step_mode_q, step_mode_d;
    logic [TO_WIDTH-1:0]   wd_q, wd_d;
    logic                  imem_req_q, imem_req_d;
    logic                  dmem_req_q, dmem_req_d;
    logic                  dmem_we_q, dmem_we_d;
    logic                  pc_en_q, pc_en_d;
    logic                  reg_we_q, reg_we_d;
    logic                  busy_q, busy_d;
    logic                  fault_q, fault_d;
    logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]  instr_cnt_q, instr_cnt_d;

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        wd_d        = wd_q;
        case (state_q)
            S_IDLE: begin
                if (step) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b1;
                    wd_d        = '0;
                end else if (run && !halt_req) begin
                    state_d     = S_FETCH;
                    step_mode_d = 1'b0;
                    wd_d        = '0;
                end
            end
            S_FETCH: begin
                // An ack arriving on the last allowed cycle still completes the fetch.
                if (imem_ack)             state_d = S_DECODE;
                else if (wd_q == WD_LAST) state_d = S_FAULT;
                else                      wd_d    = wd_q + 1'b1;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_mem_op) begin
                    state_d = S_MEM;
                    wd_d    = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack)             state_d = S_WB;
                else if (wd_q == WD_LAST) state_d = S_FAULT;
                else                      wd_d    = wd_q + 1'b1;
            end
            S_WB: begin
                if (step_mode_q || halt_req || !run) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                    wd_d    = '0;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing but ir_en has a combinational input path;
    // the decoded write flags are stable for the whole instruction, so a one-cycle capture is exact.
    always_comb begin
        imem_req_d  = (state_d == S_FETCH);
        dmem_req_d  = (state_d == S_MEM);
        dmem_we_d   = (state_d == S_MEM) && mem_is_write;
        pc_en_d     = (state_d == S_WB);
        reg_we_d    = (state_d == S_WB) && reg_write_req;
        busy_d      = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC) ||
                      (state_d == S_MEM)   || (state_d == S_WB);
        fault_d     = (state_d == S_FAULT);
        cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(busy_q);
        instr_cnt_d = instr_cnt_q + CNT_WIDTH'(state_q == S_WB);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            step_mode_q <= 1'b0;
            wd_q        <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            pc_en_q     <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            wd_q        <= wd_d;
            imem_req_q  <= imem_req_d;
            dmem_req_q  <= dmem_req_d;
            dmem_we_q   <= dmem_we_d;
            pc_en_q     <= pc_en_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign ir_en     = (state_q == S_FETCH) && imem_ack;
    assign phase     = state_q;
    assign imem_req  = imem_req_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign pc_en     = pc_en_q;
    assign reg_we    = reg_we_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule
